// File: rtl/mult_share_arbiter.sv
// Shares one pipelined multiplier among N_REQ requesters and returns each product tagged with its requester ID.
// Build macro MUL_ARB_FIXED_PRIO_EN selects fixed lowest-index priority; undefined gives round-robin.
module mult_share_arbiter #(
   parameter int N_REQ       = 4,
   parameter int DATA_W      = 8,
   parameter int MUL_LATENCY = 4,
   localparam int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1,
   localparam int P_W        = 2 * DATA_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*DATA_W-1:0] a_flat,
   input  logic [N_REQ*DATA_W-1:0] b_flat,
   output logic [N_REQ-1:0]        grant,
   output logic [DATA_W-1:0]       mul_a,
   output logic [DATA_W-1:0]       mul_b,
   input  logic [P_W-1:0]          mul_product,
   output logic                    rsp_valid,
   output logic [ID_W-1:0]         rsp_id,
   output logic [P_W-1:0]          rsp_product,
   output logic                    busy
);
   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } tag_t;

   logic [DATA_W-1:0] w_a_arr [N_REQ];
   logic [DATA_W-1:0] w_b_arr [N_REQ];
   logic              w_any;
   logic [ID_W-1:0]   w_win;
   logic              w_tag_busy;

   logic [N_REQ-1:0]  r_grant;
   logic [DATA_W-1:0] r_mul_a;
   logic [DATA_W-1:0] r_mul_b;
   tag_t              r_issue;
   tag_t              r_tag [MUL_LATENCY];
   logic              r_rsp_valid;
   logic [ID_W-1:0]   r_rsp_id;
   logic [P_W-1:0]    r_rsp_product;

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
         assign w_a_arr[gi] = a_flat[gi*DATA_W +: DATA_W];
         assign w_b_arr[gi] = b_flat[gi*DATA_W +: DATA_W];
      end
   endgenerate

   assign w_any = |req;

`ifdef MUL_ARB_FIXED_PRIO_EN
   always_comb begin
      w_win = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req[i]) w_win = ID_W'(i);
      end
   end
`else
   logic [ID_W-1:0] r_ptr;
   logic [ID_W:0]   w_idx;

   // Scan from farthest to nearest so the first requester after r_ptr wins.
   always_comb begin
      w_win = '0;
      w_idx = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         w_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
         if (w_idx >= (ID_W+1)'(N_REQ)) w_idx = w_idx - (ID_W+1)'(N_REQ);
         if (req[w_idx[ID_W-1:0]]) w_win = w_idx[ID_W-1:0];
      end
   end
`endif

   // r_issue rides alongside mul_a/mul_b; r_tag then tracks the multiplier latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_grant       <= '0;
         r_mul_a       <= '0;
         r_mul_b       <= '0;
         r_issue       <= '0;
         for (int k = 0; k < MUL_LATENCY; k++) r_tag[k] <= '0;
         r_rsp_valid   <= 1'b0;
         r_rsp_id      <= '0;
         r_rsp_product <= '0;
`ifndef MUL_ARB_FIXED_PRIO_EN
         r_ptr         <= ID_W'(N_REQ - 1);
`endif
      end else begin
         if (w_any) begin
            r_grant <= N_REQ'(1) << w_win;
            r_mul_a <= w_a_arr[w_win];
            r_mul_b <= w_b_arr[w_win];
            r_issue <= {1'b1, w_win};
`ifndef MUL_ARB_FIXED_PRIO_EN
            r_ptr   <= w_win;
`endif
         end else begin
            r_grant       <= '0;
            r_issue.valid <= 1'b0;
         end
         r_tag[0] <= r_issue;
         for (int k = 1; k < MUL_LATENCY; k++) r_tag[k] <= r_tag[k-1];
         r_rsp_valid <= r_tag[MUL_LATENCY-1].valid;
         r_rsp_id    <= r_tag[MUL_LATENCY-1].id;
         if (r_tag[MUL_LATENCY-1].valid) r_rsp_product <= mul_product;
      end
   end

   always_comb begin
      w_tag_busy = r_issue.valid;
      for (int k = 0; k < MUL_LATENCY; k++) w_tag_busy = w_tag_busy | r_tag[k].valid;
   end

   assign grant       = r_grant;
   assign mul_a       = r_mul_a;
   assign mul_b       = r_mul_b;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_id      = r_rsp_id;
   assign rsp_product = r_rsp_product;
   assign busy        = w_tag_busy | r_rsp_valid;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: behavioural multiplier plus a cycle-scheduled scoreboard of grants and responses.
// Honours MUL_ARB_FIXED_PRIO_EN the same way as the design.
module tb_mult_share_arbiter;
   localparam int N    = 4;
   localparam int DW   = 8;
   localparam int L    = 4;
   localparam int IDW  = 2;
   localparam int PW   = 16;
   localparam int RING = 64;

   logic            clk    = 1'b0;
   logic            rst_n  = 1'b0;
   logic [N-1:0]    req    = '0;
   logic [N*DW-1:0] a_flat = '0;
   logic [N*DW-1:0] b_flat = '0;
   logic [N-1:0]    grant;
   logic [DW-1:0]   mul_a;
   logic [DW-1:0]   mul_b;
   logic [PW-1:0]   mul_product;
   logic            rsp_valid;
   logic [IDW-1:0]  rsp_id;
   logic [PW-1:0]   rsp_product;
   logic            busy;

   int checks = 0;
   int errors = 0;

   mult_share_arbiter #(.N_REQ(N), .DATA_W(DW), .MUL_LATENCY(L)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .a_flat(a_flat), .b_flat(b_flat),
      .grant(grant), .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_product(rsp_product), .busy(busy)
   );

   always #5 clk = ~clk;

   // Shared multiplier: product valid L edges after mul_a/mul_b are registered.
   logic [PW-1:0] mpipe [L];
   always @(posedge clk) begin
      mpipe[0] <= {{DW{1'b0}}, mul_a} * {{DW{1'b0}}, mul_b};
      for (int k = 1; k < L; k++) mpipe[k] <= mpipe[k-1];
   end
   assign mul_product = mpipe[L-1];

   // Reference: each issued op is scheduled to appear on rsp L+1 edges after its grant edge.
   int unsigned    cyc;
   int             m_last;
   bit             sched_v  [RING];
   int             sched_id [RING];
   logic [PW-1:0]  sched_p  [RING];
   bit             issued   [RING];
   logic [N-1:0]   exp_grant;
   logic [DW-1:0]  exp_a, exp_b;
   logic           exp_rv;
   logic [IDW-1:0] exp_rid;
   logic [PW-1:0]  exp_rp;
   logic           exp_busy;

   always @(posedge clk or negedge rst_n) begin
      int w;
      if (!rst_n) begin
         for (int s = 0; s < RING; s++) begin
            sched_v[s] = 1'b0; issued[s] = 1'b0; sched_id[s] = 0; sched_p[s] = '0;
         end
         cyc = 0; m_last = N - 1;
         exp_grant = '0; exp_a = '0; exp_b = '0; exp_rv = 1'b0; exp_rid = '0; exp_rp = '0; exp_busy = 1'b0;
      end else begin
         cyc = cyc + 1;
         w = -1;
`ifdef MUL_ARB_FIXED_PRIO_EN
         for (int i = N - 1; i >= 0; i--) if (req[i]) w = i;
`else
         for (int k = N; k >= 1; k--) if (req[(m_last + k) % N]) w = (m_last + k) % N;
         if (w >= 0) m_last = w;
`endif
         if (w >= 0) begin
            exp_grant = '0;
            exp_grant[w] = 1'b1;
            exp_a = a_flat[w*DW +: DW];
            exp_b = b_flat[w*DW +: DW];
            sched_v[(cyc + L + 1) % RING]  = 1'b1;
            sched_id[(cyc + L + 1) % RING] = w;
            sched_p[(cyc + L + 1) % RING]  = PW'(exp_a) * PW'(exp_b);
            issued[cyc % RING] = 1'b1;
         end else begin
            exp_grant = '0;
            issued[cyc % RING] = 1'b0;
         end
         exp_rv = sched_v[cyc % RING];
         if (exp_rv) begin
            exp_rid = IDW'(sched_id[cyc % RING]);
            exp_rp  = sched_p[cyc % RING];
         end
         sched_v[cyc % RING] = 1'b0;
         exp_busy = 1'b0;
         for (int k = 0; k <= L + 1; k++) if (issued[(cyc - k) % RING]) exp_busy = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (rsp_valid === 1'b1) $display("rsp t=%0t id=%0d product=%0d", $time, rsp_id, rsp_product);
   end

   task automatic do_reset;
      rst_n = 1'b0; req = '0; a_flat = '0; b_flat = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      @(negedge clk);
      #1;
      checks++;
      if ({grant, mul_a, mul_b, rsp_valid, rsp_id, rsp_product, busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got g=%b a=%0d b=%0d v=%b id=%0d p=%0d busy=%b want all zero",
                  grant, mul_a, mul_b, rsp_valid, rsp_id, rsp_product, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single_op;
      int seen = 0;
      do_reset();
      req = 4'b0001; a_flat[0 +: DW] = 8'd12; b_flat[0 +: DW] = 8'd10;
      @(negedge clk);
      checks++;
      if (grant !== 4'b0001) begin
         errors++; $display("FAIL single_grant got %b want 0001", grant);
      end
      req = '0;
      for (int c = 1; c <= L + 3; c++) begin
         @(negedge clk);
         checks++;
         if ({grant, mul_a, mul_b, rsp_valid, rsp_id, rsp_product, busy} !== {exp_grant, exp_a, exp_b, exp_rv, exp_rid, exp_rp, exp_busy}) begin
            errors++;
            $display("FAIL single_model cyc=%0d got g=%b a=%0d b=%0d v=%b id=%0d p=%0d busy=%b want g=%b a=%0d b=%0d v=%b id=%0d p=%0d busy=%b",
                     cyc, grant, mul_a, mul_b, rsp_valid, rsp_id, rsp_product, busy, exp_grant, exp_a, exp_b, exp_rv, exp_rid, exp_rp, exp_busy);
         end
         if (rsp_valid === 1'b1) begin
            seen++;
            checks++;
            if (c != L + 1 || rsp_id !== 0 || rsp_product !== 16'd120) begin
               errors++;
               $display("FAIL single_rsp got delay=%0d id=%0d p=%0d want delay=%0d id=0 p=120", c, rsp_id, rsp_product, L + 1);
            end
         end
      end
      checks++;
      if (seen != 1) begin
         errors++; $display("FAIL single_count got %0d pulses want 1", seen);
      end
   endtask

   task automatic test_all_req;
      logic [N-1:0] gq[$];
      int idq[$];
      int pq[$];
      int eid;
      logic [N-1:0] eg;
      do_reset();
      req = '1;
      for (int i = 0; i < N; i++) begin
         a_flat[i*DW +: DW] = DW'(i + 1);
         b_flat[i*DW +: DW] = 8'd3;
      end
      for (int c = 0; c < 8 + L + 3; c++) begin
         if (c == 8) req = '0;
         @(negedge clk);
         checks++;
         if ({grant, mul_a, mul_b, rsp_valid, rsp_id, rsp_product, busy} !== {exp_grant, exp_a, exp_b, exp_rv, exp_rid, exp_rp, exp_busy}) begin
            errors++;
            $display("FAIL allreq_model cyc=%0d got g=%b a=%0d b=%0d v=%b id=%0d p=%0d busy=%b want g=%b a=%0d b=%0d v=%b id=%0d p=%0d busy=%b",
                     cyc, grant, mul_a, mul_b, rsp_valid, rsp_id, rsp_product, busy, exp_grant, exp_a, exp_b, exp_rv, exp_rid, exp_rp, exp_busy);
         end
         if (c < 8) gq.push_back(grant);
         if (rsp_valid === 1'b1) begin
            idq.push_back(int'(rsp_id));
            pq.push_back(int'(rsp_product));
         end
      end
      checks++;
      if (idq.size() != 8) begin
         errors++; $display("FAIL allreq_count got %0d responses want 8", idq.size());
      end
      for (int k = 0; k < 8; k++) begin
`ifdef MUL_ARB_FIXED_PRIO_EN
         eid = 0;
`else
         eid = k % N;
`endif
         eg = '0;
         eg[eid] = 1'b1;
         checks++;
         if (gq[k] !== eg) begin
            errors++; $display("FAIL allreq_grant k=%0d got %b want %b", k, gq[k], eg);
         end
         if (k < idq.size()) begin
            checks++;
            if (idq[k] != eid || pq[k] != 3 * (eid + 1)) begin
               errors++; $display("FAIL allreq_rsp k=%0d got id=%0d p=%0d want id=%0d p=%0d", k, idq[k], pq[k], eid, 3 * (eid + 1));
            end
         end
      end
   endtask

   task automatic test_back_to_back;
      int n = 0;
      int got = 0;
      int last_c = -1;
      do_reset();
      req = 4'b0100; a_flat[2*DW +: DW] = 8'd1; b_flat[2*DW +: DW] = 8'd255;
      for (int c = 0; c < 5 + L + 4; c++) begin
         @(negedge clk);
         checks++;
         if ({grant, mul_a, mul_b, rsp_valid, rsp_id, rsp_product, busy} !== {exp_grant, exp_a, exp_b, exp_rv, exp_rid, exp_rp, exp_busy}) begin
            errors++;
            $display("FAIL b2b_model cyc=%0d got g=%b a=%0d b=%0d v=%b id=%0d p=%0d busy=%b want g=%b a=%0d b=%0d v=%b id=%0d p=%0d busy=%b",
                     cyc, grant, mul_a, mul_b, rsp_valid, rsp_id, rsp_product, busy, exp_grant, exp_a, exp_b, exp_rv, exp_rid, exp_rp, exp_busy);
         end
         if (rsp_valid === 1'b1) begin
            checks++;
            if (rsp_id !== 2 || rsp_product !== PW'(255 * (got + 1)) || (got > 0 && c != last_c + 1)) begin
               errors++;
               $display("FAIL b2b_rsp n=%0d got id=%0d p=%0d gap=%0d want id=2 p=%0d gap=1", got, rsp_id, rsp_product, c - last_c, 255 * (got + 1));
            end
            last_c = c;
            got++;
         end
         if (req[2] && grant[2] === 1'b1) begin
            n++;
            if (n < 5) a_flat[2*DW +: DW] = DW'(n + 1);
            else req = '0;
         end
      end
      checks++;
      if (n != 5 || got != 5) begin
         errors++; $display("FAIL b2b_count got grants=%0d rsps=%0d want 5 and 5", n, got);
      end
   endtask

   task automatic test_reset_midflight;
      logic [N-1:0] eg;
      do_reset();
      req = 4'b0111;
      for (int i = 0; i < N; i++) begin
         a_flat[i*DW +: DW] = DW'($urandom);
         b_flat[i*DW +: DW] = DW'($urandom);
      end
      for (int c = 0; c < 5; c++) begin
         if (c == 3) req = '0;
         @(negedge clk);
         checks++;
         if ({grant, mul_a, mul_b, rsp_valid, rsp_id, rsp_product, busy} !== {exp_grant, exp_a, exp_b, exp_rv, exp_rid, exp_rp, exp_busy}) begin
            errors++;
            $display("FAIL midrst_model cyc=%0d got g=%b a=%0d b=%0d v=%b id=%0d p=%0d busy=%b want g=%b a=%0d b=%0d v=%b id=%0d p=%0d busy=%b",
                     cyc, grant, mul_a, mul_b, rsp_valid, rsp_id, rsp_product, busy, exp_grant, exp_a, exp_b, exp_rv, exp_rid, exp_rp, exp_busy);
         end
         if (c < 3) begin
`ifdef MUL_ARB_FIXED_PRIO_EN
            eg = 4'b0001;
`else
            eg = '0;
            eg[c] = 1'b1;
`endif
            checks++;
            if (grant !== eg) begin
               errors++; $display("FAIL midrst_grant c=%0d got %b want %b", c, grant, eg);
            end
         end
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({grant, mul_a, mul_b, rsp_valid, rsp_id, rsp_product, busy} !== '0) begin
         errors++;
         $display("FAIL midrst_zero got g=%b a=%0d b=%0d v=%b id=%0d p=%0d busy=%b want all zero",
                  grant, mul_a, mul_b, rsp_valid, rsp_id, rsp_product, busy);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < L + 4; c++) begin
         @(negedge clk);
         checks++;
         if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_product !== '0) begin
            errors++; $display("FAIL midrst_after c=%0d got v=%b busy=%b p=%0d want 0 0 0", c, rsp_valid, busy, rsp_product);
         end
      end
   endtask

`ifndef MUL_ARB_FIXED_PRIO_EN
   task automatic test_ptr_wrap;
      logic [N-1:0] want [3];
      want[0] = 4'b1000; want[1] = 4'b0001; want[2] = 4'b1000;
      do_reset();
      a_flat = {8'd7, 8'd9, 8'd11, 8'd13};
      b_flat = {8'd2, 8'd4, 8'd6, 8'd8};
      req = 4'b1000;
      for (int c = 0; c < 3 + L + 3; c++) begin
         @(negedge clk);
         checks++;
         if ({grant, mul_a, mul_b, rsp_valid, rsp_id, rsp_product, busy} !== {exp_grant, exp_a, exp_b, exp_rv, exp_rid, exp_rp, exp_busy}) begin
            errors++;
            $display("FAIL wrap_model cyc=%0d got g=%b a=%0d b=%0d v=%b id=%0d p=%0d busy=%b want g=%b a=%0d b=%0d v=%b id=%0d p=%0d busy=%b",
                     cyc, grant, mul_a, mul_b, rsp_valid, rsp_id, rsp_product, busy, exp_grant, exp_a, exp_b, exp_rv, exp_rid, exp_rp, exp_busy);
         end
         if (c < 3) begin
            checks++;
            if (grant !== want[c]) begin
               errors++; $display("FAIL wrap_grant c=%0d got %b want %b", c, grant, want[c]);
            end
         end
         if (c == 0) req = 4'b1001;
         if (c == 2) req = '0;
      end
   endtask
`else
   task automatic test_fixed_prio;
      int hi_grants = 0;
      do_reset();
      a_flat = {8'd7, 8'd9, 8'd11, 8'd13};
      b_flat = {8'd2, 8'd4, 8'd6, 8'd8};
      req = 4'b0011;
      for (int c = 0; c < 4 + L + 3; c++) begin
         @(negedge clk);
         checks++;
         if ({grant, mul_a, mul_b, rsp_valid, rsp_id, rsp_product, busy} !== {exp_grant, exp_a, exp_b, exp_rv, exp_rid, exp_rp, exp_busy}) begin
            errors++;
            $display("FAIL fixed_model cyc=%0d got g=%b a=%0d b=%0d v=%b id=%0d p=%0d busy=%b want g=%b a=%0d b=%0d v=%b id=%0d p=%0d busy=%b",
                     cyc, grant, mul_a, mul_b, rsp_valid, rsp_id, rsp_product, busy, exp_grant, exp_a, exp_b, exp_rv, exp_rid, exp_rp, exp_busy);
         end
         if (grant[1] === 1'b1) hi_grants++;
         if (c < 4) begin
            checks++;
            if (grant !== 4'b0001) begin
               errors++; $display("FAIL fixed_grant c=%0d got %b want 0001", c, grant);
            end
         end
         if (c == 3) req = '0;
      end
      checks++;
      if (hi_grants != 0) begin
         errors++; $display("FAIL fixed_starve got %0d grants to id 1 want 0", hi_grants);
      end
   endtask
`endif

   task automatic test_random;
      bit pend [N];
      do_reset();
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      for (int c = 0; c < 400 + L + 3; c++) begin
         @(negedge clk);
         checks++;
         if ({grant, mul_a, mul_b, rsp_valid, rsp_id, rsp_product, busy} !== {exp_grant, exp_a, exp_b, exp_rv, exp_rid, exp_rp, exp_busy}) begin
            errors++;
            $display("FAIL random_model cyc=%0d got g=%b a=%0d b=%0d v=%b id=%0d p=%0d busy=%b want g=%b a=%0d b=%0d v=%b id=%0d p=%0d busy=%b",
                     cyc, grant, mul_a, mul_b, rsp_valid, rsp_id, rsp_product, busy, exp_grant, exp_a, exp_b, exp_rv, exp_rid, exp_rp, exp_busy);
         end
         for (int i = 0; i < N; i++) begin
            if (c >= 400) begin
               pend[i] = 1'b0;
               req[i] = 1'b0;
            end else if (pend[i] && grant[i] === 1'b1) begin
               if ($urandom_range(0, 1) == 1) begin
                  a_flat[i*DW +: DW] = DW'($urandom);
                  b_flat[i*DW +: DW] = DW'($urandom);
               end else begin
                  pend[i] = 1'b0;
                  req[i] = 1'b0;
               end
            end else if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1'b1;
               req[i] = 1'b1;
               a_flat[i*DW +: DW] = DW'($urandom);
               b_flat[i*DW +: DW] = DW'($urandom);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_op();
      test_all_req();
      test_back_to_back();
      test_reset_midflight();
`ifndef MUL_ARB_FIXED_PRIO_EN
      test_ptr_wrap();
`else
      test_fixed_prio();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
